// File: rtl/mc_control_unit.sv
// Multicycle control sequencer: walks each instruction through IF/ID/EXE/MEM/WB
// and decodes datapath strobes and selects from the state register and opcode.
module mc_control_unit #(
   parameter int OP_W = 6,
   parameter int ST_W = 4
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic [OP_W-1:0] opCode,
   input  logic            zero,
   output logic            PCWre,
   output logic            IRWre,
   output logic            InsMemRW,
   output logic            ExtSel,
   output logic            ALUSrcA,
   output logic            ALUSrcB,
   output logic            RegWre,
   output logic [1:0]      RegDst,
   output logic            WrRegDSrc,
   output logic            DBDataSrc,
   output logic            DataMemRW,
   output logic [1:0]      PCSrc,
   output logic [2:0]      ALUOp,
   output logic [ST_W-1:0] state,
   output logic            halted
);

   typedef enum logic [ST_W-1:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EXE_AL = 4'd2,
      S_WB_AL  = 4'd3,
      S_EXE_BR = 4'd4,
      S_EXE_LS = 4'd5,
      S_MEM    = 4'd6,
      S_WB_LD  = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
   localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b000010;
   localparam logic [OP_W-1:0] OP_OR    = 6'b010000;
   localparam logic [OP_W-1:0] OP_AND   = 6'b010001;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
   localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
   localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'b100111;
   localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
   localparam logic [OP_W-1:0] OP_J     = 6'b111000;
   localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
   localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

   typedef struct packed {
      logic       valid;
      logic [2:0] alu_op;
      logic       src_a;
      logic       src_b;
      logic       ext_sel;
      logic       imm;
   } alu_ctl_t;

   // ALU-class decode; valid=0 means the opcode is not an ALU instruction.
   function automatic alu_ctl_t alu_decode(input logic [OP_W-1:0] op);
      alu_ctl_t c;
      c = '{valid: 1'b1, alu_op: 3'b000, src_a: 1'b0, src_b: 1'b0, ext_sel: 1'b1, imm: 1'b0};
      case (op)
         OP_ADD:   c.alu_op = 3'b000;
         OP_SUB:   c.alu_op = 3'b001;
         OP_ADDI:  begin c.alu_op = 3'b000; c.src_b = 1'b1; c.imm = 1'b1; end
         OP_OR:    c.alu_op = 3'b011;
         OP_AND:   c.alu_op = 3'b100;
         OP_ORI:   begin c.alu_op = 3'b011; c.src_b = 1'b1; c.ext_sel = 1'b0; c.imm = 1'b1; end
         OP_SLL:   begin c.alu_op = 3'b010; c.src_a = 1'b1; end
         OP_SLT:   c.alu_op = 3'b110;
         OP_SLTIU: begin c.alu_op = 3'b101; c.src_b = 1'b1; c.imm = 1'b1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   state_t   r_state;
   state_t   w_next_state;
   alu_ctl_t w_alu;

   // State register with synchronous reset to IF.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= S_IF;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and output decode; reset overrides everything at the end.
   always_comb begin
      w_next_state = S_IF;
      w_alu        = alu_decode(opCode);
      PCWre        = 1'b0;
      IRWre        = 1'b0;
      InsMemRW     = 1'b0;
      ExtSel       = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 1'b0;
      RegWre       = 1'b0;
      RegDst       = 2'b00;
      WrRegDSrc    = 1'b0;
      DBDataSrc    = 1'b0;
      DataMemRW    = 1'b0;
      PCSrc        = 2'b00;
      ALUOp        = 3'b000;
      halted       = 1'b0;
      state        = r_state;

      case (r_state)
         S_IF: begin
            IRWre        = 1'b1;
            InsMemRW     = 1'b1;
            w_next_state = S_ID;
         end
         S_ID: begin
            case (opCode)
               OP_J: begin
                  PCWre = 1'b1;
                  PCSrc = 2'b11;
               end
               OP_JR: begin
                  PCWre = 1'b1;
                  PCSrc = 2'b10;
               end
               OP_JAL: begin
                  PCWre     = 1'b1;
                  PCSrc     = 2'b11;
                  RegWre    = 1'b1;
                  RegDst    = 2'b00;
                  WrRegDSrc = 1'b0;
               end
               OP_HALT:      w_next_state = S_HALT;
               OP_BEQ:       w_next_state = S_EXE_BR;
               OP_SW, OP_LW: w_next_state = S_EXE_LS;
               default: begin
                  if (w_alu.valid) begin
                     w_next_state = S_EXE_AL;
                  end else begin
                     PCWre = 1'b1;
                     PCSrc = 2'b00;
                  end
               end
            endcase
         end
         S_EXE_AL: begin
            ALUOp   = w_alu.alu_op;
            ALUSrcA = w_alu.src_a;
            ALUSrcB = w_alu.src_b;
            ExtSel  = w_alu.ext_sel;
            // An opcode that changed mid-instruction retires as a nop.
            if (w_alu.valid) begin
               w_next_state = S_WB_AL;
            end else begin
               PCWre = 1'b1;
            end
         end
         S_WB_AL: begin
            ALUOp     = w_alu.alu_op;
            ALUSrcA   = w_alu.src_a;
            ALUSrcB   = w_alu.src_b;
            ExtSel    = w_alu.ext_sel;
            RegWre    = w_alu.valid;
            DBDataSrc = 1'b0;
            WrRegDSrc = 1'b1;
            if (w_alu.imm) begin
               RegDst = 2'b01;
            end else begin
               RegDst = 2'b10;
            end
            PCWre = 1'b1;
            PCSrc = 2'b00;
         end
         S_EXE_BR: begin
            ALUOp   = 3'b001;
            ALUSrcB = 1'b0;
            ExtSel  = 1'b1;
            PCWre   = 1'b1;
            if (zero) begin
               PCSrc = 2'b01;
            end else begin
               PCSrc = 2'b00;
            end
         end
         S_EXE_LS: begin
            ALUOp        = 3'b000;
            ALUSrcB      = 1'b1;
            ExtSel       = 1'b1;
            w_next_state = S_MEM;
         end
         S_MEM: begin
            ALUOp   = 3'b000;
            ALUSrcB = 1'b1;
            ExtSel  = 1'b1;
            if (opCode == OP_SW) begin
               DataMemRW = 1'b1;
               PCWre     = 1'b1;
            end else if (opCode == OP_LW) begin
               w_next_state = S_WB_LD;
            end else begin
               PCWre = 1'b1;
            end
         end
         S_WB_LD: begin
            DBDataSrc = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = 2'b01;
            RegWre    = 1'b1;
            PCWre     = 1'b1;
            PCSrc     = 2'b00;
         end
         S_HALT: begin
            halted       = 1'b1;
            w_next_state = S_HALT;
         end
         default: w_next_state = S_IF;
      endcase

      if (Reset) begin
         w_next_state = S_IF;
         PCWre        = 1'b0;
         IRWre        = 1'b0;
         InsMemRW     = 1'b0;
         ExtSel       = 1'b0;
         ALUSrcA      = 1'b0;
         ALUSrcB      = 1'b0;
         RegWre       = 1'b0;
         RegDst       = 2'b00;
         WrRegDSrc    = 1'b0;
         DBDataSrc    = 1'b0;
         DataMemRW    = 1'b0;
         PCSrc        = 2'b00;
         ALUOp        = 3'b000;
         halted       = 1'b0;
         state        = '0;
      end else begin
         state = r_state;
      end
   end

endmodule
